// File: rtl/audio_recorder.sv
// audio_recorder: captures left-channel I2S samples from an audio codec ADC
// and emits one SRAM write per sample. Recording can be started, paused,
// resumed and stopped. The block stops writing once the last address is used.
//
// Ports:
//   i_clk        codec BCLK; all logic runs on its rising edge
//   i_rst        synchronous active-high reset
//   i_init_done  codec configuration finished (level); gates i_start
//   i_start      start a fresh recording from IDLE or resume from PAUSE (pulse)
//   i_pause      pause recording, dropping any partial sample (pulse)
//   i_stop       return to IDLE from any state (pulse)
//   i_lrc        codec ADCLRCK, low = left channel
//   i_adcdat     codec serial ADC data, MSB first
//   o_data       captured left sample, valid with o_wr
//   o_address    SRAM word address, valid with o_wr
//   o_wr         one-cycle write strobe
//   o_length     samples written since the last fresh start
//   o_full       last writable address has been written
//   o_state      current state encoding
module audio_recorder #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned MAX_ADDR = 2**ADDR_W - 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_init_done,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_lrc,
  input  logic              i_adcdat,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_wr,
  output logic [ADDR_W:0]   o_length,
  output logic              o_full,
  output logic [2:0]        o_state
);

  localparam int unsigned       CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WRITE = 3'd3,
    ST_PAUSE = 3'd4,
    ST_FULL  = 3'd5
  } state_t;

  state_t            state;
  logic              lrc_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] shift_reg;
  logic [DATA_W-1:0] sample_next;
  logic [ADDR_W-1:0] next_addr;
  logic              lrc_fall;
  logic              start_ok;

  assign lrc_fall    = lrc_d & ~i_lrc;
  // A coinciding pause outranks start everywhere.
  assign start_ok    = i_start & i_init_done & ~i_pause;
  // Only DATA_W-1 bits are kept; the incoming bit completes the sample.
  assign sample_next = {shift_reg, i_adcdat};
  assign o_state     = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      lrc_d     <= 1'b1;
      bit_cnt   <= '0;
      shift_reg <= '0;
      next_addr <= '0;
      o_data    <= '0;
      o_address <= '0;
      o_wr      <= 1'b0;
      o_length  <= '0;
      o_full    <= 1'b0;
    end else begin
      lrc_d <= i_lrc;
      o_wr  <= 1'b0;
      if (i_stop) begin
        if (state != ST_IDLE) begin
          state  <= ST_IDLE;
          o_full <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_ok) begin
              o_length  <= '0;
              next_addr <= '0;
              state     <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (i_pause) begin
              state <= ST_PAUSE;
            end else if (lrc_fall) begin
              // I2S one-bit delay slot: data on this edge is not sampled.
              bit_cnt <= '0;
              state   <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (i_pause) begin
              state <= ST_PAUSE;
            end else begin
              shift_reg <= sample_next[DATA_W-2:0];
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                // Strobe is registered here so it is high while in WRITE.
                o_wr      <= 1'b1;
                o_data    <= sample_next;
                o_address <= next_addr;
                o_length  <= o_length + 1'b1;
                state     <= ST_WRITE;
              end
            end
          end
          ST_WRITE: begin
            // The strobe is already out; a pause here only affects what follows.
            if (o_address == LAST_ADDR) begin
              o_full <= 1'b1;
              state  <= ST_FULL;
            end else begin
              next_addr <= next_addr + 1'b1;
              state     <= i_pause ? ST_PAUSE : ST_WAIT;
            end
          end
          ST_PAUSE: begin
            if (start_ok) begin
              state <= ST_WAIT;
            end
          end
          ST_FULL: begin
            state <= ST_FULL;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_recorder.sv
// Bench for audio_recorder: two instances share one stimulus stream, one with
// default parameters and one with MAX_ADDR=3. The driver keeps a recording
// session model per instance and queues the writes each frame must produce;
// a compare process checks strobe, data, address and length every cycle.
module tb_audio_recorder;

  typedef struct {
    int unsigned  due;
    logic [15:0]  data;
    logic [19:0]  addr;
    int unsigned  len;
  } wr_t;

  logic        clk = 1'b0;
  logic        i_rst, i_init_done, i_start, i_pause, i_stop, i_lrc, i_adcdat;
  logic [15:0] o_data    [2];
  logic [19:0] o_address [2];
  logic        o_wr      [2];
  logic [20:0] o_length  [2];
  logic        o_full    [2];
  logic [2:0]  o_state   [2];

  int unsigned cyc = 0;
  logic        rst_seen = 1'b1;
  bit          cmp_en = 1'b0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  wr_t         q0[$];
  wr_t         q1[$];
  logic [15:0] last_data [2];
  logic [19:0] last_addr [2];
  int unsigned wr_count  [2];
  int unsigned wr_cyc    [2];
  int unsigned fall_cyc;

  // Session model: 0 idle, 1 recording, 2 paused, 3 memory used up.
  int unsigned sess   [2];
  int unsigned m_addr [2];
  int unsigned m_len  [2];
  int unsigned max_a  [2];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= i_rst;
  end

  audio_recorder #(.DATA_W(16), .ADDR_W(20)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_init_done(i_init_done), .i_start(i_start),
    .i_pause(i_pause), .i_stop(i_stop), .i_lrc(i_lrc), .i_adcdat(i_adcdat),
    .o_data(o_data[0]), .o_address(o_address[0]), .o_wr(o_wr[0]),
    .o_length(o_length[0]), .o_full(o_full[0]), .o_state(o_state[0])
  );

  audio_recorder #(.DATA_W(16), .ADDR_W(20), .MAX_ADDR(3)) dut_m3 (
    .i_clk(clk), .i_rst(i_rst), .i_init_done(i_init_done), .i_start(i_start),
    .i_pause(i_pause), .i_stop(i_stop), .i_lrc(i_lrc), .i_adcdat(i_adcdat),
    .o_data(o_data[1]), .o_address(o_address[1]), .o_wr(o_wr[1]),
    .o_length(o_length[1]), .o_full(o_full[1]), .o_state(o_state[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void push_exp(input int k, input wr_t w);
    if (k == 0) q0.push_back(w);
    else        q1.push_back(w);
  endfunction

  // Per-cycle compare against the queued writes.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int k = 0; k < 2; k++) begin
          wr_t h;
          bit  due;
          due = 1'b0;
          if (rst_seen) begin
            if (k == 0) q0.delete();
            else        q1.delete();
            last_data[k] = '0;
            last_addr[k] = '0;
          end
          if (k == 0) begin
            if (q0.size() != 0 && q0[0].due == cyc) begin h = q0.pop_front(); due = 1'b1; end
          end else begin
            if (q1.size() != 0 && q1[0].due == cyc) begin h = q1.pop_front(); due = 1'b1; end
          end
          chk($sformatf("o_wr[%0d]", k), 32'(o_wr[k]), 32'(due));
          if (o_wr[k] === 1'b1) begin
            wr_count[k]++;
            wr_cyc[k] = cyc;
          end
          if (due) begin
            chk($sformatf("wr_data[%0d]", k), 32'(o_data[k]), 32'(h.data));
            chk($sformatf("wr_addr[%0d]", k), 32'(o_address[k]), 32'(h.addr));
            chk($sformatf("wr_len[%0d]", k), 32'(o_length[k]), h.len);
            last_data[k] = h.data;
            last_addr[k] = h.addr;
          end else begin
            chk($sformatf("hold_data[%0d]", k), 32'(o_data[k]), 32'(last_data[k]));
            chk($sformatf("hold_addr[%0d]", k), 32'(o_address[k]), 32'(last_addr[k]));
          end
        end
      end
    end
  end

  // Returns just after a rising edge; inputs set now are sampled at the next one.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (i_init_done) begin
        if (sess[k] == 0) begin
          sess[k] = 1; m_len[k] = 0; m_addr[k] = 0;
        end else if (sess[k] == 2) begin
          sess[k] = 1;
        end
      end
    end
  endtask

  task automatic pulse_stop();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    for (int k = 0; k < 2; k++) sess[k] = 0;
  endtask

  // One I2S frame of 40 cycles. pause_bit / rst_bit (1..16) raise i_pause /
  // i_rst on the edge that captures that bit of the left word; 0 = never.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int pause_bit, input int rst_bit);
    fall_cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (sess[k] == 1 && pause_bit == 0 && rst_bit == 0) begin
        wr_t w;
        w.due  = fall_cyc + 16;
        w.data = l;
        w.addr = 20'(m_addr[k]);
        w.len  = m_len[k] + 1;
        push_exp(k, w);
        m_len[k]++;
        if (m_addr[k] == max_a[k]) sess[k] = 3;
        else m_addr[k]++;
      end
      if (pause_bit != 0 && sess[k] == 1) sess[k] = 2;
      if (rst_bit != 0) begin
        sess[k] = 0; m_len[k] = 0; m_addr[k] = 0;
      end
    end
    i_lrc = 1'b0;
    i_adcdat = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      i_adcdat = l[15-i];
      i_pause  = (i + 1 == pause_bit);
      i_rst    = (i + 1 == rst_bit);
      tick();
    end
    i_pause = 1'b0;
    i_rst = 1'b0;
    i_adcdat = 1'b0;
    repeat (3) tick();
    i_lrc = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      i_adcdat = r[15-i];
      tick();
    end
    i_adcdat = 1'b0;
    repeat (3) tick();
  endtask

  task automatic clr_counts();
    wr_count[0] = 0;
    wr_count[1] = 0;
  endtask

  initial begin
    i_rst = 1'b1; i_init_done = 1'b0; i_start = 1'b0; i_pause = 1'b0;
    i_stop = 1'b0; i_lrc = 1'b1; i_adcdat = 1'b0;
    max_a[0] = 20'hFFFFF; max_a[1] = 3;
    for (int k = 0; k < 2; k++) begin
      sess[k] = 0; m_addr[k] = 0; m_len[k] = 0;
      last_data[k] = '0; last_addr[k] = '0; wr_count[k] = 0; wr_cyc[k] = 0;
    end
    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_state[%0d]", k), 32'(o_state[k]), 0);
      chk($sformatf("rst_len[%0d]", k), 32'(o_length[k]), 0);
      chk($sformatf("rst_full[%0d]", k), 32'(o_full[k]), 0);
    end

    // start ignored while codec not initialised
    pulse_start();
    tick();
    chk("noinit_state", 32'(o_state[0]), 0);
    i_init_done = 1'b1;
    tick();

    // single word: latency and contents
    clr_counts();
    pulse_start();
    chk("start_wait", 32'(o_state[0]), 1);
    tick();
    send_frame(16'hA5C3, 16'h5A5A, 0, 0);
    chk("latency", wr_cyc[0] + 1 - fall_cyc, 17);
    chk("one_write", wr_count[0], 1);
    chk("a5c3_data", 32'(o_data[0]), 32'hA5C3);
    chk("a5c3_addr", 32'(o_address[0]), 0);
    chk("a5c3_len", 32'(o_length[0]), 1);
    pulse_stop();
    chk("stop_idle", 32'(o_state[0]), 0);

    // three frames, right words all ones
    clr_counts();
    pulse_start();
    send_frame(16'h0001, 16'hFFFF, 0, 0);
    send_frame(16'h0002, 16'hFFFF, 0, 0);
    send_frame(16'h0003, 16'hFFFF, 0, 0);
    chk("three_writes", wr_count[0], 3);
    chk("three_data", 32'(o_data[0]), 3);
    chk("three_addr", 32'(o_address[0]), 2);
    chk("three_len", 32'(o_length[0]), 3);
    pulse_stop();

    // pause mid-sample, then resume
    clr_counts();
    pulse_start();
    send_frame(16'h1111, 16'h0000, 0, 0);
    send_frame(16'h2222, 16'h0000, 8, 0);
    chk("pause_state", 32'(o_state[0]), 4);
    chk("pause_len", 32'(o_length[0]), 1);
    pulse_start();
    chk("resume_wait", 32'(o_state[0]), 1);
    send_frame(16'h3333, 16'h0000, 0, 0);
    chk("resume_addr", 32'(o_address[0]), 1);
    chk("resume_data", 32'(o_data[0]), 32'h3333);
    chk("resume_len", 32'(o_length[0]), 2);
    chk("resume_writes", wr_count[0], 2);
    pulse_stop();

    // fill the MAX_ADDR=3 instance
    clr_counts();
    pulse_start();
    for (int f = 0; f < 6; f++) send_frame(16'(16'h0010 + f), 16'hFFFF, 0, 0);
    chk("m3_writes", wr_count[1], 4);
    chk("m3_state", 32'(o_state[1]), 5);
    chk("m3_full", 32'(o_full[1]), 1);
    chk("m3_len", 32'(o_length[1]), 4);
    chk("m3_addr", 32'(o_address[1]), 3);
    chk("m3_data", 32'(o_data[1]), 32'h0013);
    chk("def_writes", wr_count[0], 6);
    chk("def_addr", 32'(o_address[0]), 5);
    chk("def_full", 32'(o_full[0]), 0);
    pulse_stop();
    chk("m3_stop_state", 32'(o_state[1]), 0);
    chk("m3_stop_full", 32'(o_full[1]), 0);
    chk("m3_stop_len", 32'(o_length[1]), 4);

    // start and stop together from WAIT
    pulse_start();
    chk("ss_wait", 32'(o_state[0]), 1);
    i_start = 1'b1;
    i_stop = 1'b1;
    tick();
    i_start = 1'b0;
    i_stop = 1'b0;
    for (int k = 0; k < 2; k++) sess[k] = 0;
    chk("ss_idle", 32'(o_state[0]), 0);

    // reset on the edge that would launch the write
    clr_counts();
    pulse_start();
    send_frame(16'hBEEF, 16'h0000, 0, 16);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rw_state[%0d]", k), 32'(o_state[k]), 0);
      chk($sformatf("rw_len[%0d]", k), 32'(o_length[k]), 0);
      chk($sformatf("rw_full[%0d]", k), 32'(o_full[k]), 0);
      chk($sformatf("rw_data[%0d]", k), 32'(o_data[k]), 0);
      chk($sformatf("rw_addr[%0d]", k), 32'(o_address[k]), 0);
      chk($sformatf("rw_count[%0d]", k), wr_count[k], 0);
    end
    pulse_start();
    chk("post_rst_start", 32'(o_state[0]), 1);
    pulse_stop();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
